// File: rtl/wb_priority_arbiter.sv
// Write-back arbiter: fixed-priority grant with per-unit aging for multi-cycle units,
// a 1-entry registered output stage, pipeline stall and WAW-driven ID/EXE clear.

module wb_arb_age #(
    parameter bit MULTI     = 1'b0,
    parameter int AGE_LIMIT = 8,
    parameter int AGE_W     = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic valid,
    input  logic elig,
    input  logic ready,
    output logic starved
);
    logic [AGE_W-1:0] age;

    // Single-cycle units keep a constant-zero counter so the instance shape is uniform.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            age <= '0;
        else if (!MULTI || !valid || ready)
            age <= '0;
        else if (age < AGE_W'(AGE_LIMIT))
            age <= age + AGE_W'(1);
    end

    assign starved = MULTI && (AGE_LIMIT != 0) && elig && (age >= AGE_W'(AGE_LIMIT));
endmodule

module wb_priority_arbiter #(
    parameter int                   NUM_UNITS  = 9,
    parameter int                   DATA_W     = 32,
    parameter int                   TAG_W      = 5,
    parameter logic [NUM_UNITS-1:0] MULTI_MASK = 9'b0_0011_1111,
    parameter int                   AGE_LIMIT  = 8,
    parameter int                   AGE_W      = 4,
    localparam int                  UNIT_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_UNITS-1:0]        req_valid,
    input  logic [NUM_UNITS*DATA_W-1:0] req_data,
    input  logic [NUM_UNITS*TAG_W-1:0]  req_rd,
    input  logic [NUM_UNITS-1:0]        req_start,
    input  logic                        rd_busy,
    input  logic                        out_ready,
    output logic [NUM_UNITS-1:0]        req_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [TAG_W-1:0]            out_rd,
    output logic [UNIT_W-1:0]           out_unit,
    output logic                        pipe_stall,
    output logic                        id_exe_clr
);
    logic [NUM_UNITS-1:0][DATA_W-1:0] data_arr;
    logic [NUM_UNITS-1:0][TAG_W-1:0]  rd_arr;
    logic [NUM_UNITS-1:0]             elig, starved, cand, grant;
    logic [UNIT_W-1:0]                win_idx;
    logic                             adv;

    assign data_arr = req_data;
    assign rd_arr   = req_rd;
    assign adv      = ~out_valid | out_ready;
    assign elig     = req_valid & (MULTI_MASK | ~{NUM_UNITS{rd_busy}});

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
        wb_arb_age #(
            .MULTI     (MULTI_MASK[g]),
            .AGE_LIMIT (AGE_LIMIT),
            .AGE_W     (AGE_W)
        ) u_age (
            .clk     (clk),
            .reset_n (reset_n),
            .valid   (req_valid[g]),
            .elig    (elig[g]),
            .ready   (grant[g]),
            .starved (starved[g])
        );
    end

    // Starved units form their own priority tier above the ordinary eligible set.
    assign cand = (|starved) ? starved : elig;

    always_comb begin
        win_idx = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--)
            if (cand[i]) win_idx = UNIT_W'(i);
    end

    assign grant      = (adv && reset_n && |cand) ? (NUM_UNITS'(1) << win_idx) : '0;
    assign req_ready  = grant;
    assign pipe_stall = |(req_valid & ~MULTI_MASK & ~grant);
    assign id_exe_clr = pipe_stall & |(grant & req_start & MULTI_MASK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_rd    <= '0;
            out_unit  <= '0;
        end else if (adv) begin
            out_valid <= |grant;
            if (|grant) begin
                out_data <= data_arr[win_idx];
                out_rd   <= rd_arr[win_idx];
                out_unit <= win_idx;
            end
        end
    end
endmodule

// File: tb/tb_wb_priority_arbiter.sv
// Bench for wb_priority_arbiter: directed scenarios plus randomized traffic,
// all cycles checked against a queue-based reference model of the arbitration rules.

module tb_wb_priority_arbiter;
    localparam int N  = 9;
    localparam int DW = 32;
    localparam int TW = 5;
    localparam int AL = 8;
    localparam logic [N-1:0] MM = 9'b0_0011_1111;

    logic            clk, reset_n;
    logic [N-1:0]    rv, rstart, rdy;
    logic [N*DW-1:0] rdata;
    logic [N*TW-1:0] rrd;
    logic            busy, ordy;
    logic            out_valid, pipe_stall, id_exe_clr;
    logic [DW-1:0]   out_data;
    logic [TW-1:0]   out_rd;
    logic [3:0]      out_unit;

    int tests = 0, fails = 0;

    // reference model state
    int          age_m[N];
    bit          ov_m;
    logic [DW-1:0] od_m;
    logic [TW-1:0] ord_m;
    int          ou_m;
    int          win_m;
    bit          pend[N];

    wb_priority_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req_valid(rv), .req_data(rdata), .req_rd(rrd),
        .req_start(rstart), .rd_busy(busy), .out_ready(ordy), .req_ready(rdy),
        .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd), .out_unit(out_unit),
        .pipe_stall(pipe_stall), .id_exe_clr(id_exe_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) age_m[i] = 0;
        ov_m = 0; od_m = '0; ord_m = '0; ou_m = 0;
    endtask

    // Starved candidates outrank everything; within a tier the lowest index wins.
    function automatic int pick();
        int st[$];
        int el[$];
        if (!reset_n || !(!ov_m || ordy)) return -1;
        for (int i = 0; i < N; i++) begin
            if (rv[i] && (MM[i] || !busy)) begin
                el.push_back(i);
                if (MM[i] && AL != 0 && age_m[i] >= AL) st.push_back(i);
            end
        end
        if (st.size() > 0) return st[0];
        if (el.size() > 0) return el[0];
        return -1;
    endfunction

    task automatic check_all();
        logic [N-1:0] eg;
        bit st, clr;
        eg = (win_m < 0) ? '0 : (N'(1) << win_m);
        st = 0;
        for (int i = 0; i < N; i++)
            if (rv[i] && !MM[i] && i != win_m) st = 1;
        clr = st && win_m >= 0 && MM[win_m] && rstart[win_m];
        chk("req_ready", 64'(rdy), 64'(eg));
        chk("pipe_stall", 64'(pipe_stall), 64'(st));
        chk("id_exe_clr", 64'(id_exe_clr), 64'(clr));
        chk("out_valid", 64'(out_valid), 64'(ov_m));
        chk("out_data", 64'(out_data), 64'(od_m));
        chk("out_rd", 64'(out_rd), 64'(ord_m));
        chk("out_unit", 64'(out_unit), 64'(ou_m));
    endtask

    task automatic settle();
        #2;
        win_m = pick();
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else begin
            if (!ov_m || ordy) begin
                ov_m = (win_m >= 0);
                if (win_m >= 0) begin
                    od_m  = rdata[win_m*DW +: DW];
                    ord_m = rrd[win_m*TW +: TW];
                    ou_m  = win_m;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!MM[i] || !rv[i] || i == win_m) age_m[i] = 0;
                else if (age_m[i] < AL) age_m[i]++;
            end
        end
        #1;
    endtask

    initial begin
        reset_n = 1'b0; rv = '0; rstart = '0; busy = 1'b0; ordy = 1'b1;
        for (int i = 0; i < N; i++) begin
            rdata[i*DW +: DW] = $urandom();
            rrd[i*TW +: TW]   = TW'($urandom());
            pend[i] = 0;
        end
        model_reset();
        #1;
        settle();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // T1: lone single-cycle unit 8
        rv = 9'h100;
        settle();
        chk("t1_ready", 64'(rdy), 64'h100);
        chk("t1_stall", 64'(pipe_stall), 64'd0);
        tick(); rv = '0;
        settle();
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_unit", 64'(out_unit), 64'd8);
        chk("t1_out_data", 64'(out_data), 64'(rdata[8*DW +: DW]));
        tick();

        // T2: units 1 and 8 compete
        rv = 9'h102;
        settle();
        chk("t2_c0_ready", 64'(rdy), 64'h002);
        chk("t2_c0_stall", 64'(pipe_stall), 64'd1);
        tick(); rv = 9'h100;
        settle();
        chk("t2_c1_ready", 64'(rdy), 64'h100);
        chk("t2_c1_stall", 64'(pipe_stall), 64'd0);
        tick(); rv = '0;
        settle(); tick();

        // T3: rd_busy blocks single-cycle unit 7
        rv = 9'h080; busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("t3_blk_ready", 64'(rdy), 64'd0);
            chk("t3_blk_stall", 64'(pipe_stall), 64'd1);
            chk("t3_blk_out_valid", 64'(out_valid), 64'd0);
            tick();
        end
        busy = 1'b0;
        settle();
        chk("t3_ready", 64'(rdy), 64'h080);
        tick(); rv = '0;
        settle(); tick();

        // T4: aging promotes unit 5 over unit 0 after AGE_LIMIT losses
        for (int c = 0; c < 10; c++) begin
            rv = (c < 9) ? 9'h021 : 9'h001;
            settle();
            if (c < 8)       chk("t4_unit0_wins", 64'(rdy), 64'h001);
            else if (c == 8) chk("t4_unit5_promoted", 64'(rdy), 64'h020);
            else             chk("t4_unit0_after", 64'(rdy), 64'h001);
            tick();
        end
        rv = '0;
        settle(); tick();

        // T5: WAW clear when the winner was just issued into
        rv = 9'h044; rstart = 9'h004;
        settle();
        chk("t5_ready", 64'(rdy), 64'h004);
        chk("t5_stall", 64'(pipe_stall), 64'd1);
        chk("t5_clr", 64'(id_exe_clr), 64'd1);
        tick(); rstart = '0;
        settle();
        chk("t5_noclr_ready", 64'(rdy), 64'h004);
        chk("t5_noclr", 64'(id_exe_clr), 64'd0);
        tick(); rv = 9'h040;
        settle(); tick(); rv = '0;
        settle(); tick();

        // T6: back-pressure hold, then asynchronous reset mid-operation
        rv = 9'h008;
        settle(); tick();
        rv = 9'h010; ordy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("t6_hold_valid", 64'(out_valid), 64'd1);
            chk("t6_hold_unit", 64'(out_unit), 64'd3);
            chk("t6_hold_ready", 64'(rdy), 64'd0);
            tick();
        end
        reset_n = 1'b0;
        #1; model_reset();
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        settle();
        tick();
        reset_n = 1'b1; ordy = 1'b1;
        settle();
        chk("t6_regrant", 64'(rdy), 64'h010);
        tick(); rv = '0;
        settle();
        chk("t6_regrant_unit", 64'(out_unit), 64'd4);
        tick();

        // Randomized traffic honouring the hold-while-not-granted rule
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
                    pend[i] = 1;
                    rdata[i*DW +: DW] = $urandom();
                    rrd[i*TW +: TW]   = TW'($urandom());
                end
                rv[i] = pend[i];
            end
            busy   = ($urandom_range(3, 0) == 0);
            ordy   = ($urandom_range(3, 0) != 0);
            rstart = N'($urandom());
            settle();
            tick();
            if (win_m >= 0) pend[win_m] = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
